// File: rtl/tbec_pkg.sv
// Shared definitions for the TBEC (two-dimensional block error code) decoder:
// codeword field positions, single-bit syndrome columns and the decode helper.
package tbec_pkg;

    localparam int unsigned CW_W   = 32;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned SYN_W  = 16;

    // Codeword field LSB positions: data rows, DI group, P group, X group
    localparam int unsigned DATA_LSB = 16;
    localparam int unsigned DI_LSB   = 12;
    localparam int unsigned P_LSB    = 8;
    localparam int unsigned X_LSB    = 0;

    // Syndrome column of each data bit, indexed by its out_data position
    localparam logic [SYN_W-1:0] SYN_COL [DATA_W-1:0] = '{
        16'h8880, 16'h2840, 16'h1180, 16'h4140,   // A1..A4
        16'h2820, 16'h8810, 16'h4120, 16'h1110,   // B1..B4
        16'h8208, 16'h2204, 16'h1408, 16'h4404,   // C1..C4
        16'h2202, 16'h8201, 16'h4402, 16'h1401    // D1..D4
    };

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              corrected;
        logic              uncorrectable;
        logic [SYN_W-1:0]  syndrome;
    } tbec_result_t;

    // Row-major codeword data (A1,B1,C1,D1,A2,...) to column-major {A1..A4,...,D1..D4}
    function automatic logic [DATA_W-1:0] data_of(input logic [CW_W-1:0] cw);
        logic [DATA_W-1:0] d;
        d = '0;
        for (int l = 0; l < 4; l++) begin
            for (int r = 0; r < 4; r++) begin
                d[15 - 4*l - r] = cw[31 - 4*r - l];
            end
        end
        return d;
    endfunction

    function automatic tbec_result_t decode(input logic [CW_W-1:0] cw,
                                            input logic [SYN_W-1:0] syn);
        tbec_result_t res;
        logic         hit;
        logic         one_hot;
        res.data          = data_of(cw);
        res.syndrome      = syn;
        res.corrected     = 1'b0;
        res.uncorrectable = 1'b0;
        hit               = 1'b0;
        for (int i = 0; i < DATA_W; i++) begin
            if (syn == SYN_COL[i]) begin
                res.data[i] = ~res.data[i];
                hit         = 1'b1;
            end
        end
        one_hot = (syn != '0) && ((syn & (syn - SYN_W'(1))) == '0);
        if (hit || one_hot) begin
            res.corrected = 1'b1;
        end else if (syn != '0) begin
            res.uncorrectable = 1'b1;
        end
        return res;
    endfunction

endpackage

// File: rtl/tbec_syndrome.sv
// Combinational TBEC syndrome: recomputed check bits XOR received check bits,
// in the codeword's own check-field bit order.
module tbec_syndrome
    import tbec_pkg::*;
(
    input  logic [31:0] codeword_i,
    output logic [15:0] syndrome_o
);

    logic [15:0] d;
    logic [15:0] chk;

    assign d = data_of(codeword_i);

    // d[15:12]=A1..A4, d[11:8]=B1..B4, d[7:4]=C1..C4, d[3:0]=D1..D4
    assign chk = {
        d[15] ^ d[10] ^ d[7]  ^ d[2],    // DI1
        d[12] ^ d[9]  ^ d[4]  ^ d[1],    // DI4
        d[14] ^ d[11] ^ d[6]  ^ d[3],    // DI2
        d[13] ^ d[8]  ^ d[5]  ^ d[0],    // DI3
        d[15] ^ d[14] ^ d[11] ^ d[10],   // P1
        d[5]  ^ d[4]  ^ d[1]  ^ d[0],    // P4
        d[7]  ^ d[6]  ^ d[3]  ^ d[2],    // P2
        d[13] ^ d[12] ^ d[9]  ^ d[8],    // P3
        d[15] ^ d[13], d[14] ^ d[12],
        d[11] ^ d[9],  d[10] ^ d[8],
        d[7]  ^ d[5],  d[6]  ^ d[4],
        d[3]  ^ d[1],  d[2]  ^ d[0]
    };

    assign syndrome_o = chk ^ codeword_i[15:0];

endmodule

// File: rtl/tbec_decoder.sv
// Two-stage TBEC decoder with valid/ready handshakes and saturating
// corrected/uncorrectable event counters.
module tbec_decoder #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_codeword,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_data,
    output logic             out_corrected,
    output logic             out_uncorrectable,
    output logic [15:0]      out_syndrome,
    input  logic             cnt_clear,
    output logic [CNT_W-1:0] corr_count,
    output logic [CNT_W-1:0] unc_count
);

    import tbec_pkg::*;

    logic             s1_valid_q;
    logic [31:0]      s1_cw_q;
    logic [15:0]      s1_syn_q;
    logic             s2_valid_q;
    tbec_result_t     s2_res_q;
    tbec_result_t     s2_res_d;
    logic [15:0]      syn;
    logic             s1_load;
    logic             s2_load;
    logic             out_hs;
    logic [CNT_W-1:0] corr_cnt_q, corr_cnt_d;
    logic [CNT_W-1:0] unc_cnt_q, unc_cnt_d;

    tbec_syndrome u_syndrome (
        .codeword_i (in_codeword),
        .syndrome_o (syn)
    );

    assign s2_load  = !s2_valid_q || out_ready;
    assign s1_load  = !s1_valid_q || s2_load;
    assign in_ready = s1_load;
    assign out_hs   = s2_valid_q && out_ready;
    assign s2_res_d = decode(s1_cw_q, s1_syn_q);

    always_comb begin
        corr_cnt_d = corr_cnt_q;
        unc_cnt_d  = unc_cnt_q;
        if (cnt_clear) begin
            corr_cnt_d = '0;
            unc_cnt_d  = '0;
        end else if (out_hs) begin
            if (s2_res_q.corrected && corr_cnt_q != '1) begin
                corr_cnt_d = corr_cnt_q + CNT_W'(1);
            end
            if (s2_res_q.uncorrectable && unc_cnt_q != '1) begin
                unc_cnt_d = unc_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_cw_q    <= '0;
            s1_syn_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_res_q   <= '0;
            corr_cnt_q <= '0;
            unc_cnt_q  <= '0;
        end else begin
            if (s1_load) begin
                s1_valid_q <= in_valid;
                if (in_valid) begin
                    s1_cw_q  <= in_codeword;
                    s1_syn_q <= syn;
                end
            end
            // Result fields only change when a new word enters S2, so they hold while stalled
            if (s2_load) begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    s2_res_q <= s2_res_d;
                end
            end
            corr_cnt_q <= corr_cnt_d;
            unc_cnt_q  <= unc_cnt_d;
        end
    end

    assign out_valid         = s2_valid_q;
    assign out_data          = s2_res_q.data;
    assign out_corrected     = s2_res_q.corrected;
    assign out_uncorrectable = s2_res_q.uncorrectable;
    assign out_syndrome      = s2_res_q.syndrome;
    assign corr_count        = corr_cnt_q;
    assign unc_count         = unc_cnt_q;

endmodule

// File: tb/tb_tbec_decoder.sv
// Directed self-checking bench for tbec_decoder (CNT_W=16 main instance and a
// CNT_W=2 instance for counter saturation and clear priority).
module tb_tbec_decoder;

    logic        clk = 1'b0;
    logic        rst;

    logic        in_valid, in_ready, out_valid, out_ready, cnt_clear;
    logic [31:0] in_codeword;
    logic [15:0] out_data, out_syndrome, corr_count, unc_count;
    logic        out_corrected, out_uncorrectable;

    logic        in_valid2, in_ready2, out_valid2, out_ready2, cnt_clear2;
    logic [31:0] in_codeword2;
    logic [15:0] out_data2, out_syndrome2;
    logic        out_corrected2, out_uncorrectable2;
    logic [1:0]  corr_count2, unc_count2;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    tbec_decoder #(.CNT_W(16)) dut (
        .clk               (clk),
        .rst               (rst),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .in_codeword       (in_codeword),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_data          (out_data),
        .out_corrected     (out_corrected),
        .out_uncorrectable (out_uncorrectable),
        .out_syndrome      (out_syndrome),
        .cnt_clear         (cnt_clear),
        .corr_count        (corr_count),
        .unc_count         (unc_count)
    );

    tbec_decoder #(.CNT_W(2)) dut2 (
        .clk               (clk),
        .rst               (rst),
        .in_valid          (in_valid2),
        .in_ready          (in_ready2),
        .in_codeword       (in_codeword2),
        .out_valid         (out_valid2),
        .out_ready         (out_ready2),
        .out_data          (out_data2),
        .out_corrected     (out_corrected2),
        .out_uncorrectable (out_uncorrectable2),
        .out_syndrome      (out_syndrome2),
        .cnt_clear         (cnt_clear2),
        .corr_count        (corr_count2),
        .unc_count         (unc_count2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One isolated word: accept, check 2-cycle latency and result, let it drain
    task automatic run_one(input logic [31:0] cw, input logic [15:0] e_data,
                           input logic e_corr, input logic e_unc, input logic [15:0] e_syn);
        @(negedge clk);
        in_valid    = 1'b1;
        in_codeword = cw;
        out_ready   = 1'b1;
        #1;
        check("accept_ready", in_ready, 1);
        @(negedge clk);
        in_valid    = 1'b0;
        in_codeword = '0;
        check("lat1_valid", out_valid, 0);
        @(negedge clk);
        check("lat2_valid", out_valid, 1);
        check("data", out_data, e_data);
        check("corrected", out_corrected, e_corr);
        check("uncorrectable", out_uncorrectable, e_unc);
        check("syndrome", out_syndrome, e_syn);
        @(negedge clk);
        check("drained", out_valid, 0);
    endtask

    task automatic send2(input logic [31:0] cw);
        @(negedge clk);
        in_valid2    = 1'b1;
        in_codeword2 = cw;
        @(negedge clk);
        in_valid2    = 1'b0;
    endtask

    initial begin
        int          tx;
        int          rx;
        logic        stalled;
        logic [15:0] held;

        rst = 1'b1;
        in_valid = 1'b0; in_codeword = '0; out_ready = 1'b1; cnt_clear = 1'b0;
        in_valid2 = 1'b0; in_codeword2 = '0; out_ready2 = 1'b1; cnt_clear2 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_syn", out_syndrome, 0);
        check("rst_flags", {out_corrected, out_uncorrectable}, 0);
        check("rst_corr_count", corr_count, 0);
        check("rst_unc_count", unc_count, 0);
        check("rst_in_ready", in_ready, 1);

        run_one(32'h0000_0000, 16'h0000, 1'b0, 1'b0, 16'h0000);
        run_one(32'h8000_8880, 16'h8000, 1'b0, 1'b0, 16'h0000);
        run_one(32'h7FFF_0000, 16'hFFFF, 1'b1, 1'b0, 16'h8880);
        check("corr_count_1", corr_count, 1);
        run_one(32'hFFFF_0001, 16'hFFFF, 1'b1, 1'b0, 16'h0001);
        run_one(32'hFFDF_0000, 16'hFFFF, 1'b1, 1'b0, 16'h1408);
        run_one(32'h77FF_0000, 16'h3FFF, 1'b0, 1'b1, 16'hA0C0);
        check("corr_count_3", corr_count, 3);
        check("unc_count_1", unc_count, 1);

        // Stream 8 check-bit-error words; word k carries syndrome 1<<k
        tx = 0; rx = 0; stalled = 1'b0; held = '0;
        for (int t = 0; t < 60 && rx < 8; t++) begin
            @(negedge clk);
            out_ready   = !(t >= 3 && t <= 5);
            in_valid    = (tx < 8);
            in_codeword = 32'h1 << tx;
            #1;
            if (stalled) check("stall_hold", out_syndrome, held);
            if (t >= 3 && t <= 5) check("stall_in_ready", in_ready, 0);
            if (in_valid && in_ready) tx++;
            if (out_valid && out_ready) begin
                check("stream_syn", out_syndrome, 16'h1 << rx);
                check("stream_corr", out_corrected, 1);
                check("stream_data", out_data, 0);
                rx++;
            end
            stalled = out_valid && !out_ready;
            held    = out_syndrome;
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("stream_tx", tx, 8);
        check("stream_rx", rx, 8);
        repeat (2) @(negedge clk);
        check("stream_drained", out_valid, 0);
        check("corr_count_11", corr_count, 11);

        cnt_clear = 1'b1;
        @(negedge clk);
        cnt_clear = 1'b0;
        check("clear_corr", corr_count, 0);
        check("clear_unc", unc_count, 0);

        // Reset with a word in flight: it must never appear
        @(negedge clk);
        in_valid    = 1'b1;
        in_codeword = 32'h0000_0001;
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("midrst_no_valid", out_valid, 0);
            @(negedge clk);
        end
        check("midrst_corr_count", corr_count, 0);

        // CNT_W=2 saturation
        @(negedge clk);
        in_valid2    = 1'b1;
        in_codeword2 = 32'h0000_0001;
        repeat (5) @(negedge clk);
        in_valid2 = 1'b0;
        repeat (4) @(negedge clk);
        check("sat_corr_count", corr_count2, 3);
        cnt_clear2 = 1'b1;
        @(negedge clk);
        cnt_clear2 = 1'b0;
        check("sat_clear", corr_count2, 0);

        // Clear coincides with a corrected handshake
        send2(32'h0000_0001);
        @(negedge clk);
        check("clr_hs_valid", out_valid2, 1);
        cnt_clear2 = 1'b1;
        @(negedge clk);
        cnt_clear2 = 1'b0;
        check("clr_priority", corr_count2, 0);
        send2(32'h0000_0001);
        repeat (2) @(negedge clk);
        check("post_clear_inc", corr_count2, 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/tbec_decoder.md
TBEC_DECODER -- requirements
Module: tbec_decoder

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of each error-event counter.
REQ-002 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have port in_valid, input, 1: in_codeword is valid.
REQ-005 SHALL have port in_ready, output, 1: the decoder accepts in_codeword this cycle.
REQ-006 SHALL have port in_codeword, input, 32: the received TBEC codeword.
REQ-007 SHALL have port out_valid, output, 1: the out_* result fields are valid.
REQ-008 SHALL have port out_ready, input, 1: the consumer accepts the result.
REQ-009 SHALL have port out_data, output, 16: the corrected data word.
REQ-010 SHALL have port out_corrected, output, 1: exactly one bit error was found and repaired.
REQ-011 SHALL have port out_uncorrectable, output, 1: the syndrome matches no single-bit pattern.
REQ-012 SHALL have port out_syndrome, output, 16: the raw syndrome, for diagnostics.
REQ-013 SHALL have port cnt_clear, input, 1: clears both counters.
REQ-014 SHALL have port corr_count, output, CNT_W: count of corrected results.
REQ-015 SHALL have port unc_count, output, CNT_W: count of uncorrectable results.

Function
REQ-016 Codeword layout SHALL be as follows:
- [31:28]={A1,B1,C1,D1}, [27:24]=row 2, [23:20]=row 3, [19:16]=row 4.
- [15:12]={DI1,DI4,DI2,DI3}.
- [11:8]={P1,P4,P2,P3}.
- [7:0]={XA13,XA24,XB13,XB24,XC13,XC24,XD13,XD24}.
- out_data SHALL be {A1..A4,B1..B4,C1..C4,D1..D4}, MSB first.
REQ-017 Check equations SHALL be:
- DI1=A1^B2^C1^D2; DI2=A2^B1^C2^D1; DI3=A3^B4^C3^D4; DI4=A4^B3^C4^D3.
- P1=A1^A2^B1^B2; P2=C1^C2^D1^D2; P3=A3^A4^B3^B4; P4=C3^C4^D3^D4.
- Xn13=n1^n3 and Xn24=n2^n4 for each of n=A,B,C,D.
REQ-018 Syndrome SHALL equal the recomputed check bits XOR the received [15:0], in the same bit order.
REQ-019 Each data bit SHALL have a unique 3-bit syndrome column (one DI, one P, one X); a syndrome equal to a data-bit column SHALL flip that data bit and set out_corrected.
REQ-020 A syndrome of zero SHALL give no flags; a syndrome of weight 1 (check-bit error) SHALL set out_corrected, with data unchanged.
REQ-021 Any other syndrome SHALL set out_uncorrectable and pass the received data bits unmodified.
REQ-022 The pipeline SHALL have two registered stages:
- S1 captures the codeword and its syndrome.
- S2 holds the corrected data and flags.
- Latency from input handshake to out_valid SHALL be 2 cycles without backpressure.
REQ-023 Stage advance rules:
- S2 loads when S2 is empty or out_ready=1.
- S1 loads when S1 is empty or S1 advances this cycle.
- in_ready SHALL equal that S1 load condition, combinationally.
- Full throughput SHALL be 1 word/cycle.
REQ-024 While out_valid=1 and out_ready=0, all out_* fields SHALL hold stable.
REQ-025 Counters SHALL increment on an output handshake (out_valid&out_ready) carrying the corresponding flag, and SHALL saturate at all-ones, never wrapping.
REQ-026 cnt_clear SHALL zero both counters the next cycle and SHALL take priority over a simultaneous increment; it SHALL not affect the pipeline.

Reset
REQ-027 On rst, both stage valids SHALL be cleared, so that out_valid=0, out_corrected=0, out_uncorrectable=0, out_data=0, out_syndrome=0, corr_count=0 and unc_count=0.
REQ-028 in_ready SHALL be 1 in the first cycle after rst deasserts.
REQ-029 rst mid-transfer SHALL discard in-flight words with no counter update.

Structure
REQ-030 Package tbec_pkg SHALL hold the codeword field position constants, the 16-entry data-bit syndrome column table and a packed struct typedef for the decode result.
REQ-031 Syndrome generation SHALL be a combinational sub-module, tbec_syndrome (32-bit in, 16-bit out), reusable by future encoders and checkers.

Verification
REQ-032 The bench SHALL cover the following directed scenarios:
- codeword 0x00000000 -> out_data 0x0000, no flags, out_valid 2 cycles after acceptance.
- codeword 0xFFFF0000 with bit 31 flipped (0x7FFF0000) -> syndrome DI1|P1|XA13 set, out_data 0xFFFF, out_corrected=1, corr_count=1.
- codeword 0xFFFF0001 (XD24 flipped) -> out_data 0xFFFF, out_corrected=1, syndrome 0x0001.
- codeword 0x77FF0000 (A1 and A2 flipped) -> out_uncorrectable=1, unc_count increments, out_data equals the received data bits.
- Streaming 8 words with out_ready low for cycles 3-5 -> no loss or duplication, outputs stable while stalled, in_ready low once both stages are full.
- CNT_W=2: 5 corrected words -> corr_count holds 3; cnt_clear together with an increment -> 0.
